// File: rtl/column_weight_pkg.sv
// Shared types and sizing helpers for the column weight store.
package column_weight_pkg;

  localparam int unsigned DEF_WW = 16 + 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SWAP
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/column_weight_bank.sv
// One weight bank: S rows of N words, word-granular write, combinational row read.
module column_weight_bank
  import column_weight_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned S  = 8,
  parameter int unsigned WW = DEF_WW,
  parameter int unsigned AW = 3,
  parameter int unsigned RW = cnt_width(S),
  parameter int unsigned LW = cnt_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [RW-1:0]   row,
  input  logic [LW-1:0]   lane,
  input  logic [WW-1:0]   data,
  input  logic [AW-1:0]   addr,
  output logic [N*WW-1:0] row_data
);

  logic [N*WW-1:0] mem [S];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < S; r++) mem[r] <= '0;
    end else if (we) begin
      mem[row][lane*WW +: WW] <= data;
    end
  end

  // Addresses at or beyond S fall through to the spare all-zero row.
  always_comb begin
    row_data = '0;
    for (int unsigned r = 0; r < S; r++) begin
      if (32'(addr) == r) row_data = mem[r];
    end
  end

endmodule

// File: rtl/column_weight_loader.sv
// Double-buffered weight loader: packs a word stream into the shadow bank, then swaps banks.
module column_weight_loader
  import column_weight_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned S         = 8,
  parameter int unsigned n         = 16,
  parameter int unsigned cl        = 8,
  parameter int unsigned addrwidth = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [n+cl-1:0]        in_data,
  input  logic                   in_last,
  output logic                   busy,
  output logic                   load_done,
  output logic                   load_err,
  input  logic [addrwidth:0]     addr,
  output logic [N*(n+cl)-1:0]    W
);

  localparam int unsigned WW = n + cl;
  localparam int unsigned LW = cnt_width(N);
  localparam int unsigned RW = cnt_width(S);

  state_t          state;
  logic            bank_sel;
  logic [LW-1:0]   word_cnt;
  logic [RW-1:0]   row_cnt;
  logic            wr;
  logic            final_beat;
  logic [N*WW-1:0] rd0;
  logic [N*WW-1:0] rd1;

  // A start coinciding with a beat restarts the load; that beat is discarded.
  assign wr         = in_valid & in_ready & ~start;
  assign final_beat = (row_cnt == RW'(S - 1)) && (word_cnt == LW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bank_sel  <= 1'b0;
      word_cnt  <= '0;
      row_cnt   <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            word_cnt <= '0;
            row_cnt  <= '0;
            state    <= ST_LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (start) begin
            word_cnt <= '0;
            row_cnt  <= '0;
          end else if (wr) begin
            if (in_last != final_beat) begin
              state    <= ST_IDLE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              load_err <= 1'b1;
            end else if (final_beat) begin
              state     <= ST_SWAP;
              in_ready  <= 1'b0;
              load_done <= 1'b1;
            end else if (word_cnt == LW'(N - 1)) begin
              word_cnt <= '0;
              row_cnt  <= row_cnt + 1'b1;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        ST_SWAP: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          bank_sel <= ~bank_sel;
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // bank_sel names the active bank; writes always target the other one.
  column_weight_bank #(
    .N(N), .S(S), .WW(WW), .AW(addrwidth + 1), .RW(RW), .LW(LW)
  ) u_bank0 (
    .clk(clk), .rst_n(rst_n), .we(wr & bank_sel),
    .row(row_cnt), .lane(word_cnt), .data(in_data),
    .addr(addr), .row_data(rd0)
  );

  column_weight_bank #(
    .N(N), .S(S), .WW(WW), .AW(addrwidth + 1), .RW(RW), .LW(LW)
  ) u_bank1 (
    .clk(clk), .rst_n(rst_n), .we(wr & ~bank_sel),
    .row(row_cnt), .lane(word_cnt), .data(in_data),
    .addr(addr), .row_data(rd1)
  );

  assign W = bank_sel ? rd1 : rd0;

endmodule

// File: tb/tb_column_weight_loader.sv
// Directed bench for column_weight_loader with a flat-array transaction model.
module tb_column_weight_loader;

  localparam int unsigned N  = 8;
  localparam int unsigned S  = 8;
  localparam int unsigned WW = 24;
  localparam int unsigned AB = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [WW-1:0]     in_data;
  logic              in_last;
  logic              busy;
  logic              load_done;
  logic              load_err;
  logic [AB-1:0]     addr;
  logic [N*WW-1:0]   W;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  int n_lerr = 0;

  column_weight_loader #(
    .N(N), .S(S), .n(16), .cl(8), .addrwidth(AB - 1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .busy(busy), .load_done(load_done), .load_err(load_err),
    .addr(addr), .W(W)
  );

  always #5 clk = ~clk;

  // Model: linear beat index 0..63, word i lands at row i/N, lane i%N.
  logic [WW-1:0] m_bank [2][S*N];
  logic          m_sel;
  logic          m_loading;
  logic          m_swap;
  logic          m_err;
  int            m_beats;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sel     <= 1'b0;
      m_loading <= 1'b0;
      m_swap    <= 1'b0;
      m_err     <= 1'b0;
      m_beats   <= 0;
      for (int i = 0; i < S*N; i++) begin
        m_bank[0][i] <= '0;
        m_bank[1][i] <= '0;
      end
    end else begin
      m_err <= 1'b0;
      if (m_swap) begin
        m_swap <= 1'b0;
        m_sel  <= ~m_sel;
      end else if (!m_loading) begin
        if (start) begin
          m_loading <= 1'b1;
          m_beats   <= 0;
        end
      end else if (start) begin
        m_beats <= 0;
      end else if (in_valid) begin
        m_bank[~m_sel][m_beats] <= in_data;
        if (in_last != (m_beats == S*N - 1)) begin
          m_loading <= 1'b0;
          m_err     <= 1'b1;
        end else if (m_beats == S*N - 1) begin
          m_loading <= 1'b0;
          m_swap    <= 1'b1;
        end else begin
          m_beats <= m_beats + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [N*WW-1:0] act, input logic [N*WW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [N*WW-1:0] exp_w;
    exp_w = '0;
    if (int'(addr) < S)
      for (int l = 0; l < N; l++) exp_w[l*WW +: WW] = m_bank[m_sel][int'(addr)*N + l];
    chk("in_ready",  N*WW'(in_ready),  N*WW'(m_loading));
    chk("busy",      N*WW'(busy),      N*WW'(m_loading | m_swap));
    chk("load_done", N*WW'(load_done), N*WW'(m_swap));
    chk("load_err",  N*WW'(load_err),  N*WW'(m_err));
    chk("W",         W,                exp_w);
    if (load_done) n_done++;
    if (load_err)  n_lerr++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_set(input logic [WW-1:0] base, input int cnt, input int last_at, input bit gaps);
    int g;
    for (int i = 1; i <= cnt; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (g) tick();
      end
      in_valid = 1'b1;
      in_data  = base | WW'(i);
      in_last  = (i == last_at);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic logic [N*WW-1:0] lane_of(input logic [N*WW-1:0] w, input int l);
    return N*WW'(w[l*WW +: WW]);
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; addr = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a <= 8; a++) begin
      addr = AB'(a);
      #1 chk("reset_W", W, '0);
    end
    chk("reset_busy", N*WW'(busy), '0);
    chk("reset_in_ready", N*WW'(in_ready), '0);

    // Load 1: 0x000001..0x000040
    addr = '0;
    pulse_start();
    send_set(24'h000000, 64, 64, 1'b0);
    chk("done_pulse_1", N*WW'(load_done), N*WW'(1));
    tick();
    chk("done_cleared", N*WW'(load_done), '0);
    #1 chk("l1_a0_lane0", lane_of(W, 0), N*WW'(24'h000001));
    chk("l1_a0_lane7", lane_of(W, 7), N*WW'(24'h000008));
    addr = 4'd7;
    #1 chk("l1_a7_lane7", lane_of(W, 7), N*WW'(24'h000040));
    addr = 4'd8;
    #1 chk("spare_row", W, '0);

    // Load 2: 0x8400xx with addr held at 3
    addr = 4'd3;
    pulse_start();
    send_set(24'h840000, 64, 64, 1'b0);
    chk("l2_old_row3_in_swap", lane_of(W, 0), N*WW'(24'h000019));
    tick();
    chk("l2_new_row3", lane_of(W, 0), N*WW'(24'h840019));
    chk("done_count_2", N*WW'(n_done), N*WW'(2));

    // Early in_last on beat 10
    pulse_start();
    send_set(24'h110000, 10, 10, 1'b0);
    chk("early_last_err", N*WW'(load_err), N*WW'(1));
    chk("early_last_busy", N*WW'(busy), '0);
    tick();
    chk("early_last_W", lane_of(W, 0), N*WW'(24'h840019));

    // Missing in_last on beat 64
    pulse_start();
    send_set(24'h220000, 64, 0, 1'b0);
    chk("missing_last_err", N*WW'(load_err), N*WW'(1));
    tick(); tick();
    chk("missing_last_W", lane_of(W, 0), N*WW'(24'h840019));
    chk("err_count", N*WW'(n_lerr), N*WW'(2));
    chk("done_count_err", N*WW'(n_done), N*WW'(2));

    // Restart after 20 beats, then a full load
    pulse_start();
    send_set(24'h330000, 20, 0, 1'b0);
    pulse_start();
    send_set(24'h440000, 64, 64, 1'b0);
    tick(); tick();
    addr = 4'd0;
    #1 chk("restart_a0_lane0", lane_of(W, 0), N*WW'(24'h440001));
    chk("done_count_restart", N*WW'(n_done), N*WW'(3));

    // Gapped stream, reset mid-load, then a full gapped load into bank 1
    pulse_start();
    send_set(24'h550000, 30, 0, 1'b1);
    in_valid = 1'b1;
    in_data  = 24'h55ffff;
    #1 rst_n = 1'b0;
    #1;
    chk("async_busy", N*WW'(busy), '0);
    chk("async_in_ready", N*WW'(in_ready), '0);
    chk("async_done", N*WW'(load_done), '0);
    chk("async_err", N*WW'(load_err), '0);
    chk("async_W", W, '0);
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_set(24'h660000, 64, 64, 1'b1);
    tick(); tick();
    addr = 4'd7;
    #1 chk("post_rst_a7_lane7", lane_of(W, 7), N*WW'(24'h660040));
    chk("bank_sel_1", N*WW'(dut.bank_sel), N*WW'(1));
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
